// File: rtl/alu_arbiter_pkg.sv
// Shared definitions for the ALU arbiter slice.
// ALUOp encodings, arbiter FSM states, operand bundle.
package alu_arbiter_pkg;

  localparam logic [1:0] ALUOP_ADDU = 2'b00;
  localparam logic [1:0] ALUOP_SUBU = 2'b01;
  localparam logic [1:0] ALUOP_ORI  = 2'b10;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'b00,
    ARB_EXEC = 2'b01,
    ARB_RESP = 2'b10
  } arb_state_t;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [1:0]  op;
  } alu_req_t;

endpackage

// File: rtl/alu.sv
// Shared 32-bit ALU: ADDU, SUBU, ORI.
// Zero reports operand equality; op 11 yields 0.
module alu
  import alu_arbiter_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [1:0]  op,
  output logic [31:0] result,
  output logic        zero
);

  // Result mux on ALUOp
  always_comb begin
    result = '0;
    unique case (op)
      ALUOP_ADDU: result = a + b;
      ALUOP_SUBU: result = a - b;
      ALUOP_ORI:  result = a | b;
      default:    result = '0;
    endcase
  end

  assign zero = (a == b);

endmodule

// File: rtl/alu_arbiter_rr_picker.sv
// Round-robin selector: first valid at or after ptr.
// Pure combinational, one-hot grant plus index.
module rr_picker #(
  parameter int NREQ = 2,
  parameter int IDW  = 1
) (
  input  logic [NREQ-1:0] valid,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] grant_oh,
  output logic [IDW-1:0]  grant_id,
  output logic            any
);

  // Scan farthest-first so the nearest valid wins
  always_comb begin
    int idx;
    idx      = 0;
    grant_oh = '0;
    grant_id = '0;
    any      = 1'b0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = (int'(ptr) + k) % NREQ;
      if (valid[idx]) begin
        grant_oh      = '0;
        grant_oh[idx] = 1'b1;
        grant_id      = IDW'(idx);
        any           = 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin sharing of one ALU among NREQ requesters.
// One op in flight: accept, execute, hold response.
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int IDW  = 1,
  parameter int CNTW = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NREQ-1:0]    req_valid,
  output logic [NREQ-1:0]    req_ready,
  input  logic [32*NREQ-1:0] req_a,
  input  logic [32*NREQ-1:0] req_b,
  input  logic [2*NREQ-1:0]  req_op,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [IDW-1:0]     rsp_id,
  output logic [31:0]        rsp_result,
  output logic               rsp_zero,
  output logic [CNTW-1:0]    op_count
);

  arb_state_t      state_q;
  arb_state_t      state_d;
  logic [IDW-1:0]  rr_ptr;
  logic [IDW-1:0]  id_q;
  logic [IDW-1:0]  id_nxt;
  alu_req_t        req_q;
  alu_req_t        sel;
  logic [NREQ-1:0] grant_oh;
  logic [IDW-1:0]  gid;
  logic            any;
  logic [31:0]     alu_res;
  logic            alu_zero;

  rr_picker #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_pick (
    .valid    (req_valid),
    .ptr      (rr_ptr),
    .grant_oh (grant_oh),
    .grant_id (gid),
    .any      (any)
  );

  alu u_alu (
    .a      (req_q.a),
    .b      (req_q.b),
    .op     (req_q.op),
    .result (alu_res),
    .zero   (alu_zero)
  );

  // Operand slice of the current grantee
  always_comb begin
    sel.a  = req_a[32*int'(gid) +: 32];
    sel.b  = req_b[32*int'(gid) +: 32];
    sel.op = req_op[2*int'(gid) +: 2];
  end

  // Pointer after the serviced requester, mod NREQ
  always_comb begin
    if (id_q == IDW'(NREQ - 1)) id_nxt = '0;
    else                        id_nxt = id_q + 1'b1;
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ARB_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ARB_IDLE: if (any) state_d = ARB_EXEC;
      ARB_EXEC: state_d = ARB_RESP;
      ARB_RESP: if (rsp_ready) state_d = ARB_IDLE;
      default:  state_d = ARB_IDLE;
    endcase
  end

  // Accept strobe only while idle
  always_comb begin
    req_ready = '0;
    if (state_q == ARB_IDLE) req_ready = grant_oh;
  end

  // Operand latch, response capture, pointer, counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_q      <= '0;
      id_q       <= '0;
      rr_ptr     <= '0;
      rsp_valid  <= 1'b0;
      rsp_id     <= '0;
      rsp_result <= '0;
      rsp_zero   <= 1'b0;
      op_count   <= '0;
    end else begin
      unique case (state_q)
        ARB_IDLE: begin
          if (any) begin
            req_q <= sel;
            id_q  <= gid;
            if (op_count != '1)
              op_count <= op_count + 1'b1;
          end
        end
        ARB_EXEC: begin
          rsp_result <= alu_res;
          rsp_zero   <= alu_zero;
          rsp_id     <= id_q;
          rsp_valid  <= 1'b1;
        end
        ARB_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            rr_ptr    <= id_nxt;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Randomized bench for alu_arbiter with a cycle-level
// transaction model; 3 requesters, 2-bit counter build.
module tb_alu_arbiter;

  localparam int NREQ = 3;
  localparam int IDW  = 2;
  localparam int CNTW = 2;
  localparam int CMAX = (1 << CNTW) - 1;

  logic               clk;
  logic               rst_n;
  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_ready;
  logic [32*NREQ-1:0] req_a;
  logic [32*NREQ-1:0] req_b;
  logic [2*NREQ-1:0]  req_op;
  logic               rsp_valid;
  logic               rsp_ready;
  logic [IDW-1:0]     rsp_id;
  logic [31:0]        rsp_result;
  logic               rsp_zero;
  logic [CNTW-1:0]    op_count;

  alu_arbiter #(
    .NREQ (NREQ),
    .IDW  (IDW),
    .CNTW (CNTW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_op     (req_op),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_result (rsp_result),
    .rsp_zero   (rsp_zero),
    .op_count   (op_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // transaction model
  int          m_busy, m_ptr, m_cnt, m_cyc, m_rsp_at, m_id;
  logic [31:0] m_res;
  logic        m_zero;
  int          s_id;
  logic [31:0] s_res;
  logic        s_zero;

  // per-step observations for directed checks
  int          last_g;
  logic        hs_now;
  int          rec_id;
  logic [31:0] rec_res;
  logic        rec_zero;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h t=%0t",
               tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_alu(input logic [1:0] op,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
    case (op)
      2'd0:    return a + b;
      2'd1:    return a - b;
      2'd2:    return a | b;
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_reset();
    m_busy = 0; m_ptr = 0; m_cnt = 0;
    m_rsp_at = 0; m_id = 0;
    m_res = '0; m_zero = 1'b0;
    s_id = 0; s_res = '0; s_zero = 1'b0;
  endtask

  // One clock cycle: compare at negedge, advance model
  task automatic step();
    int g;
    int vis;
    logic [NREQ-1:0] exp_rdy;
    logic [31:0] a, b;
    logic [1:0] op;
    @(negedge clk);
    g = -1;
    exp_rdy = '0;
    if (m_busy == 0)
      for (int k = 0; k < NREQ; k++) begin
        int idx;
        idx = (m_ptr + k) % NREQ;
        if (g < 0 && req_valid[idx]) g = idx;
      end
    if (g >= 0) exp_rdy[g] = 1'b1;
    vis = (m_busy != 0 && m_cyc >= m_rsp_at) ? 1 : 0;
    check("req_ready", 32'(req_ready), 32'(exp_rdy));
    check("rsp_valid", 32'(rsp_valid), vis);
    check("rsp_id", 32'(rsp_id), s_id);
    check("rsp_result", rsp_result, s_res);
    check("rsp_zero", 32'(rsp_zero), 32'(s_zero));
    check("op_count", 32'(op_count), m_cnt);
    last_g = g;
    hs_now = (vis != 0) && rsp_ready;
    if (hs_now) begin
      rec_id   = int'(rsp_id);
      rec_res  = rsp_result;
      rec_zero = rsp_zero;
    end
    if (g >= 0) begin
      a  = req_a[32*g +: 32];
      b  = req_b[32*g +: 32];
      op = req_op[2*g +: 2];
      m_busy   = 1;
      m_id     = g;
      m_res    = ref_alu(op, a, b);
      m_zero   = (a == b);
      m_rsp_at = m_cyc + 2;
      if (m_cnt < CMAX) m_cnt++;
    end else if (m_busy != 0 && m_cyc + 1 == m_rsp_at) begin
      s_id = m_id; s_res = m_res; s_zero = m_zero;
    end else if (hs_now) begin
      m_busy = 0;
      m_ptr  = (m_id + 1) % NREQ;
    end
    m_cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int r, input logic [31:0] a,
                         input logic [31:0] b, input logic [1:0] op);
    req_a[32*r +: 32] = a;
    req_b[32*r +: 32] = b;
    req_op[2*r +: 2]  = op;
  endtask

  // Issue one op from requester r alone and check its response
  task automatic run_one(input int r, input logic [31:0] a,
                         input logic [31:0] b, input logic [1:0] op,
                         input logic [31:0] exp_res,
                         input logic exp_zero);
    int acc, got, lat;
    req_valid = '0;
    rsp_ready = 1'b1;
    set_req(r, a, b, op);
    req_valid[r] = 1'b1;
    acc = 0;
    for (int i = 0; i < 10 && acc == 0; i++) begin
      step();
      if (last_g == r) acc = 1;
    end
    req_valid[r] = 1'b0;
    check("accept", acc, 1);
    got = 0;
    lat = 0;
    for (int i = 0; i < 10 && got == 0; i++) begin
      step();
      lat++;
      if (hs_now) got = 1;
    end
    check("rsp_seen", got, 1);
    check("latency", lat, 2);
    check("res_const", rec_res, exp_res);
    check("zero_const", 32'(rec_zero), 32'(exp_zero));
    check("id_const", rec_id, r);
  endtask

  initial begin
    int n, order_ok;
    rst_n = 1'b0;
    req_valid = '0;
    req_a = '0; req_b = '0; req_op = '0;
    rsp_ready = 1'b0;
    model_reset();
    m_cyc = 0;
    last_g = -1; hs_now = 1'b0;
    rec_id = 0; rec_res = '0; rec_zero = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", 32'(rsp_valid), 0);
    check("rst_ready", 32'(req_ready), 0);
    check("rst_count", 32'(op_count), 0);
    check("rst_result", rsp_result, 0);
    rst_n = 1'b1;

    run_one(0, 32'd5, 32'd3, 2'b00, 32'd8, 1'b0);
    check("count_one", 32'(op_count), 1);
    run_one(1, 32'h1234, 32'h1234, 2'b01, 32'd0, 1'b1);
    run_one(1, 32'd0, 32'd1, 2'b01, 32'hFFFF_FFFF, 1'b0);

    // fairness: 0 and 1 both pending, expect 0,1,0,1
    set_req(0, 32'hF0, 32'h0F, 2'b10);
    set_req(1, 32'hFFFF_FFFF, 32'd1, 2'b00);
    req_valid = 3'b011;
    rsp_ready = 1'b1;
    n = 0;
    order_ok = 1;
    for (int i = 0; i < 40 && n < 4; i++) begin
      step();
      if (hs_now) begin
        if (rec_id != (n % 2)) order_ok = 0;
        check("fair_res", rec_res,
              (rec_id == 0) ? 32'hFF : 32'h0);
        n++;
      end
    end
    req_valid = '0;
    check("fair_n", n, 4);
    check("fair_order", order_ok, 1);
    step();

    // backpressure, with requester 0 waiting throughout
    set_req(2, 32'd7, 32'd9, 2'b00);
    req_valid = 3'b100;
    rsp_ready = 1'b0;
    step();
    req_valid = 3'b001;
    step();
    for (int i = 0; i < 5; i++) step();
    check("bp_hold", rsp_result, 32'd16);
    rsp_ready = 1'b1;
    step();
    check("bp_hs", 32'(hs_now), 1);
    step();
    check("bp_next", last_g, 0);
    req_valid = '0;
    repeat (3) step();

    // reset while in EXEC
    set_req(1, 32'd11, 32'd22, 2'b00);
    req_valid = 3'b010;
    step();
    req_valid = '0;
    rst_n = 1'b0;
    #1;
    check("mid_valid", 32'(rsp_valid), 0);
    check("mid_count", 32'(op_count), 0);
    check("mid_ready", 32'(req_ready), 0);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    set_req(0, 32'd2, 32'd2, 2'b00);
    set_req(1, 32'd1, 32'd1, 2'b00);
    req_valid = 3'b011;
    step();
    check("ptr_zero", last_g, 0);
    req_valid = '0;
    step();
    step();
    check("post_rst_res", rec_res, 32'd4);

    // op 11 and counter saturation
    run_one(2, 32'hABCD, 32'h1357, 2'b11, 32'd0, 1'b0);
    run_one(0, 32'd1, 32'd1, 2'b10, 32'd1, 1'b1);
    run_one(1, 32'd3, 32'd4, 2'b00, 32'd7, 1'b0);
    run_one(2, 32'd9, 32'd4, 2'b01, 32'd5, 1'b0);
    check("sat_count", 32'(op_count), CMAX);

    // random traffic
    for (int i = 0; i < 600; i++) begin
      for (int r = 0; r < NREQ; r++) begin
        logic [31:0] a;
        a = $urandom;
        req_valid[r] = ($urandom_range(0, 3) != 0);
        set_req(r, a,
                ($urandom_range(0, 3) == 0) ? a : $urandom,
                2'($urandom_range(0, 3)));
      end
      rsp_ready = ($urandom_range(0, 2) != 0);
      if (i == 300) begin
        rst_n = 1'b0;
        #1;
        check("rnd_rst", 32'(rsp_valid), 0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
      end
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
